// File: rtl/fft_bfly_pipe.sv
// -----------------------------------------------------------------------------
// fft_bfly_pipe
//   Pipelined radix-2 DIT complex butterfly:
//     sum = A + B*Wt,  dif = A - B*Wt
//   The twiddle can be conjugated per beat for the inverse transform. Each beat
//   can request a rounded divide-by-2, and results saturate to W bits. A sticky
//   flag reports clipping.
//
//   Pipeline (one global enable, three register stages):
//     stage 1 : full-precision complex product B*Wt (W+TW+1 bits)
//     stage 2 : round product back to sample scale, form a+t and a-t (W+2 bits)
//     stage 3 : optional rounded halving, saturation, output registers
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   a_re, a_im            sample A          (signed, W bits)
//   b_re, b_im            sample B          (signed, W bits)
//   tw_re, tw_im          twiddle           (signed Q1.(TW-1))
//   conj                  1 = use conj(tw), sampled with the beat
//   scale                 1 = halve results with rounding, sampled with the beat
//   out_valid / out_ready output handshake
//   sum_re, sum_im        A + B*Wt          (signed, W bits)
//   dif_re, dif_im        A - B*Wt          (signed, W bits)
//   ovf                   sticky saturation flag
//   ovf_clr               synchronous clear of ovf (a same-edge set wins)
// -----------------------------------------------------------------------------
module fft_bfly_pipe #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  a_re,
    input  logic signed [W-1:0]  a_im,
    input  logic signed [W-1:0]  b_re,
    input  logic signed [W-1:0]  b_im,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    input  logic                 conj,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  sum_re,
    output logic signed [W-1:0]  sum_im,
    output logic signed [W-1:0]  dif_re,
    output logic signed [W-1:0]  dif_im,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int PRW = W + TW;        // single product width
    localparam int PW  = W + TW + 1;    // sum of two products
    localparam int SW  = W + 2;         // a +/- t
    localparam int VW  = W + 3;         // headroom for the rounding add

    // Half an LSB of the rounded result, in product units.
    localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (TW - 2);
    localparam logic signed [VW-1:0] ONE  = {{(VW-1){1'b0}}, 1'b1};
    localparam logic signed [VW-1:0] VMAX = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [VW-1:0] VMIN = {4'b1111, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  OMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  OMIN = {1'b1, {(W-1){1'b0}}};

    genvar gi;

    // ------------------------------------------------------------------
    // Global enable: every stage advances together, so a stall freezes
    // the whole pipe and no beat can be lost or duplicated.
    // ------------------------------------------------------------------
    logic en;
    logic out_valid_reg;

    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: complex product at full precision
    // ------------------------------------------------------------------
    logic signed [PRW-1:0] b_re_x, b_im_x, tw_re_x, tw_im_x;
    logic signed [PRW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0]  rr_x, ii_x, ri_x, ir_x;
    logic signed [PW-1:0]  s1_p_next [2];
    logic signed [W-1:0]   s1_a_next [2];

    assign b_re_x  = {{TW{b_re[W-1]}}, b_re};
    assign b_im_x  = {{TW{b_im[W-1]}}, b_im};
    assign tw_re_x = {{W{tw_re[TW-1]}}, tw_re};
    assign tw_im_x = {{W{tw_im[TW-1]}}, tw_im};

    assign m_rr = b_re_x * tw_re_x;
    assign m_ii = b_im_x * tw_im_x;
    assign m_ri = b_re_x * tw_im_x;
    assign m_ir = b_im_x * tw_re_x;

    assign rr_x = {m_rr[PRW-1], m_rr};
    assign ii_x = {m_ii[PRW-1], m_ii};
    assign ri_x = {m_ri[PRW-1], m_ri};
    assign ir_x = {m_ir[PRW-1], m_ir};

    // Conjugating the twiddle flips the sign of every tw_im term.
    assign s1_p_next[0] = conj ? (rr_x + ii_x) : (rr_x - ii_x);
    assign s1_p_next[1] = conj ? (ir_x - ri_x) : (ri_x + ir_x);
    assign s1_a_next[0] = a_re;
    assign s1_a_next[1] = a_im;

    logic                 s1_valid_reg;
    logic                 s1_scale_reg;
    logic signed [W-1:0]  s1_a_reg [2];
    logic signed [PW-1:0] s1_p_reg [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_scale_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                s1_a_reg[i] <= '0;
                s1_p_reg[i] <= '0;
            end
        end else if (en) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_scale_reg <= scale;
                for (int i = 0; i < 2; i++) begin
                    s1_a_reg[i] <= s1_a_next[i];
                    s1_p_reg[i] <= s1_p_next[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round-half-up back to sample scale, then add/subtract.
    // Index map used from here on: 0 sum_re, 1 sum_im, 2 dif_re, 3 dif_im.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] s2_v_next [4];

    for (gi = 0; gi < 2; gi++) begin : g_s2
        logic signed [PW-1:0] p_rnd;
        logic signed [PW-1:0] p_sh;
        logic signed [W:0]    t;
        logic signed [SW-1:0] a_x;
        logic signed [SW-1:0] t_x;
        logic                 unused_hi;

        assign p_rnd = s1_p_reg[gi] + RND;
        assign p_sh  = p_rnd >>> (TW - 1);
        assign t     = p_sh[W:0];
        // Only W+1 bits of the shifted product are carried forward.
        assign unused_hi = ^p_sh[PW-1:W+1];

        assign a_x = {{2{s1_a_reg[gi][W-1]}}, s1_a_reg[gi]};
        assign t_x = {t[W], t};

        assign s2_v_next[gi]     = a_x + t_x;
        assign s2_v_next[gi + 2] = a_x - t_x;
    end

    logic                 s2_valid_reg;
    logic                 s2_scale_reg;
    logic signed [SW-1:0] s2_v_reg [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_scale_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s2_v_reg[i] <= '0;
            end
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_scale_reg <= s1_scale_reg;
                for (int i = 0; i < 4; i++) begin
                    s2_v_reg[i] <= s2_v_next[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: optional rounded halving, then saturate to W bits
    // ------------------------------------------------------------------
    logic signed [W-1:0] sat_v [4];
    logic [3:0]          clip;

    for (gi = 0; gi < 4; gi++) begin : g_s3
        logic signed [VW-1:0] v_x;
        logic signed [VW-1:0] v_sc;

        assign v_x  = {s2_v_reg[gi][SW-1], s2_v_reg[gi]};
        assign v_sc = s2_scale_reg ? ((v_x + ONE) >>> 1) : v_x;

        assign clip[gi]  = (v_sc > VMAX) || (v_sc < VMIN);
        assign sat_v[gi] = (v_sc > VMAX) ? OMAX :
                           (v_sc < VMIN) ? OMIN : v_sc[W-1:0];
    end

    // A clip only counts when a real beat actually moves into the outputs.
    logic ovf_reg;
    logic ovf_set;
    logic ovf_next;

    assign ovf_set  = en && s2_valid_reg && (|clip);
    assign ovf_next = ovf_set || (ovf_reg && !ovf_clr);

    logic signed [W-1:0] out_v_reg [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                out_v_reg[i] <= '0;
            end
        end else begin
            ovf_reg <= ovf_next;
            if (en) begin
                out_valid_reg <= s2_valid_reg;
                // Bubbles advance the valid bit but leave the data outputs alone.
                if (s2_valid_reg) begin
                    for (int i = 0; i < 4; i++) begin
                        out_v_reg[i] <= sat_v[i];
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign ovf       = ovf_reg;
    assign sum_re    = out_v_reg[0];
    assign sum_im    = out_v_reg[1];
    assign dif_re    = out_v_reg[2];
    assign dif_im    = out_v_reg[3];

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_pipe
//   Directed vectors with hand-computed results. The driver pushes the expected
//   result of every accepted beat into a queue. A monitor on the falling edge
//   pops and compares whenever the DUT hands off a result (out_valid &&
//   out_ready).
// -----------------------------------------------------------------------------
module tb_fft_bfly_pipe;

    localparam int W  = 16;
    localparam int TW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] tw_re, tw_im;
    logic                 conj, scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  sum_re, sum_im, dif_re, dif_im;
    logic                 ovf;
    logic                 ovf_clr;

    fft_bfly_pipe #(.W(W), .TW(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .conj     (conj),
        .scale    (scale),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_re   (sum_re),
        .sum_im   (sum_im),
        .dif_re   (dif_re),
        .dif_im   (dif_im),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int s_re;
        int s_im;
        int d_re;
        int d_im;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int beat_id  = 0;
    int n_pop    = 0;
    int last_cons_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor: one line per completed output transaction.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got sum=(%0d,%0d) with no beat outstanding",
                         sum_re, sum_im);
            end else begin
                mon_e = q.pop_front();
                $display("out  beat %0d: sum=(%0d,%0d) dif=(%0d,%0d) ovf=%0b",
                         mon_e.id, sum_re, sum_im, dif_re, dif_im, ovf);
                chk($sformatf("b%0d sum_re", mon_e.id), int'(sum_re), mon_e.s_re);
                chk($sformatf("b%0d sum_im", mon_e.id), int'(sum_im), mon_e.s_im);
                chk($sformatf("b%0d dif_re", mon_e.id), int'(dif_re), mon_e.d_re);
                chk($sformatf("b%0d dif_im", mon_e.id), int'(dif_im), mon_e.d_im);
                n_pop++;
                last_cons_cyc = cyc + 1;
            end
        end
    end

    // Present one beat, wait for acceptance and record its expected result.
    // Returns 1 time unit after the accepting clock edge.
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int twr, input int twi, input logic cj, input logic sc,
                        input int esr, input int esi, input int edr, input int edi);
        exp_t e;
        int   waited;
        a_re  = W'(ar);
        a_im  = W'(ai);
        b_re  = W'(br);
        b_im  = W'(bi);
        tw_re = TW'(twr);
        tw_im = TW'(twi);
        conj  = cj;
        scale = sc;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.id   = beat_id;
            e.s_re = esr;
            e.s_im = esi;
            e.d_re = edr;
            e.d_im = edi;
            q.push_back(e);
            $display("in   beat %0d: a=(%0d,%0d) b=(%0d,%0d) tw=(%0d,%0d) conj=%0b scale=%0b",
                     beat_id, ar, ai, br, bi, twr, twi, cj, sc);
            beat_id++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int n_stall;
        int pops_before;
        int ghost;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        tw_re = '0; tw_im = '0; conj = 1'b0; scale = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst sum_re", int'(sum_re), 0);
        chk("rst dif_im", int'(dif_im), 0);
        chk("rst ovf", int'(ovf), 0);
        chk("rst in_ready", int'(in_ready), 1);

        // Identity twiddle with latency: accepted at edge N, result registered
        // at edge N+2 and handed off on edge N+3.
        send(1000, -200, 100, 50, 32767, 0, 1'b0, 1'b0, 1100, -150, 900, -250);
        chk("lat after N", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat after N+1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat after N+2", int'(out_valid), 1);
        chk("ident ovf", int'(ovf), 0);
        drain();

        // -j twiddle, plain and conjugated
        send(0, 0, 100, 50, 0, -32768, 1'b0, 1'b0, 50, -100, -50, 100);
        send(0, 0, 100, 50, 0, -32768, 1'b1, 1'b0, -50, 100, 50, -100);
        // Rounded halving of negative odd values: (-149)>>>1 = -75
        send(1000, -200, 100, 50, 32767, 0, 1'b0, 1'b1, 550, -75, 450, -125);
        drain();
        chk("no-clip ovf", int'(ovf), 0);

        // Positive saturation
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0);
        drain();
        chk("sat ovf set", int'(ovf), 1);
        pulse_clr();
        chk("sat ovf cleared", int'(ovf), 0);
        // Same beat halved: no clipping
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1, 32767, 0, 1, 0);
        drain();
        chk("scaled ovf", int'(ovf), 0);
        // Negative saturation: -32768 - 32766 clips to -32768
        send(-32768, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, -2, 0, -32768, 0);
        drain();
        chk("negsat ovf", int'(ovf), 1);
        pulse_clr();

        // Back-pressure: 8 beats, out_ready low in cycles 4..7
        n_stall = 0;
        pops_before = n_pop;
        start_cyc = cyc;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send(0, 0, k, 0, 32767, 0, 1'b0, 1'b0, k, 0, -k, 0);
                end
            end
            begin
                for (int c = 1; c <= 20; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    if (c >= 4 && c <= 7) n_stall++;
                    @(negedge clk);
                    if (c >= 4 && c <= 7) begin
                        chk($sformatf("stall c%0d out_valid", c), int'(out_valid), 1);
                        chk($sformatf("stall c%0d in_ready", c), int'(in_ready), 0);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp beats out", n_pop - pops_before, 8);
        chk("bp total cycles", last_cons_cyc - start_cyc, 8 + 3 + n_stall);

        // Sticky flag: set wins over a same-edge clear
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0);
        drain();
        chk("sticky pre", int'(ovf), 1);
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0);
        @(posedge clk); #1;       // after N+1: beat is in stage 2
        ovf_clr = 1'b1;           // clear on edge N+2, when the beat clips
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("setwins out_valid", int'(out_valid), 1);
        chk("setwins ovf", int'(ovf), 1);
        drain();
        pulse_clr();
        chk("late clr ovf", int'(ovf), 0);

        // Reset mid-flight: prime nonzero outputs and ovf=1 first
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0);
        drain();
        chk("pre-rst ovf", int'(ovf), 1);
        send(1000, -200, 100, 50, 32767, 0, 1'b0, 1'b0, 1100, -150, 900, -250);
        send(0, 0, 100, 50, 0, -32768, 1'b0, 1'b0, 50, -100, -50, 100);
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst sum_re", int'(sum_re), 0);
        chk("midrst dif_re", int'(dif_re), 0);
        chk("midrst ovf", int'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postrst in_ready", int'(in_ready), 1);
        ghost = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        chk("postrst ghost beats", ghost, 0);
        @(posedge clk); #1;

        // Pipe still works after reset
        send(1000, -200, 100, 50, 32767, 0, 1'b0, 1'b0, 1100, -150, 900, -250);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
